// File: rtl/obc_pkg.sv
// Shared types and Q11.21 constants for the OBC coefficient ROM pipeline.
package obc_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int FRAC_W_DEF = 21;

    localparam logic [31:0] COEF_HALF_POS = 32'h0010_0000;
    localparam logic [31:0] COEF_HALF_NEG = 32'hFFF0_0000;

endpackage

// File: rtl/obc_table.sv
// One channel's DEPTH x DATA_W table: synchronous write, registered read.
// A same-edge write and read of one entry returns the pre-write contents.
module obc_table #(
    parameter int DATA_W = 32,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/obc_coef_rom_pipe.sv
// NCH loadable OBC tables with address fold and sign inversion; 2-stage valid/ready pipe, stalls hold both stages.
// OBC_SAT_EN: saturate negation of the most negative value and expose sticky sat_flag per channel.
module obc_coef_rom_pipe
    import obc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int NCH    = 4,
    parameter int K      = 3,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [K-2:0]          cfg_addr,
    input  logic [DATA_W-1:0]     cfg_data,
    output logic                  cfg_busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*K-1:0]      in_bits,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef OBC_SAT_EN
    output logic [NCH-1:0]        sat_flag,
`endif
    output logic [NCH*DATA_W-1:0] out_data
);

    localparam int AW = K - 1;
    localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};

    if (FRAC_W >= DATA_W || K < 2) begin : g_bad_cfg
        $error("obc_coef_rom_pipe: invalid FRAC_W/DATA_W/K");
    end

    state_t                  state;
    logic [AW-1:0]           init_cnt;
    logic                    en;
    logic                    accept;
    logic                    v1;
    logic [NCH-1:0]          s1;
    logic [NCH-1:0]          s_in;
    logic [NCH*DATA_W-1:0]   next_data;
    logic [NCH-1:0]          sat_hit;

    // Init walks every entry once, zeroing all tables in parallel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            cfg_busy <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + AW'(1);
                    if (init_cnt == {AW{1'b1}}) begin
                        state    <= READY;
                        cfg_busy <= 1'b0;
                    end
                end
                default: state <= READY;
            endcase
        end
    end

    assign en       = !out_valid || out_ready;
    assign in_ready = (state == READY) && en;
    assign accept   = in_valid && in_ready;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [K-1:0]      bits;
        logic [AW-1:0]     raddr;
        logic              we;
        logic [AW-1:0]     waddr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] neg;

        assign bits    = in_bits[c*K +: K];
        assign s_in[c] = bits[K-1];
        assign raddr   = bits[K-2:0] ^ {AW{bits[K-1]}};

        assign we    = (state == INIT) ||
                       (rst_n && cfg_we && (state == READY) && (cfg_ch == CH_W'(c)));
        assign waddr = (state == INIT) ? init_cnt : cfg_addr;
        assign wdata = (state == INIT) ? '0 : cfg_data;

        obc_table #(
            .DATA_W (DATA_W),
            .AW     (AW)
        ) u_table (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .re    (accept),
            .raddr (raddr),
            .rdata (rdata)
        );

        assign sat_hit[c] = s1[c] && (rdata == MIN_VAL);
`ifdef OBC_SAT_EN
        assign neg = sat_hit[c] ? MAX_VAL : (~rdata + DATA_W'(1));
`else
        assign neg = ~rdata + DATA_W'(1);
`endif
        assign next_data[c*DATA_W +: DATA_W] = s1[c] ? neg : rdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (en) begin
            v1 <= accept;
            if (accept) begin
                s1 <= s_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= v1;
            out_data  <= next_data;
        end
    end

`ifdef OBC_SAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag <= '0;
        end else if (en && v1) begin
            sat_flag <= sat_flag | sat_hit;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^{sat_hit, MAX_VAL};
`endif

endmodule

// File: tb/tb_obc_coef_rom_pipe.sv
// Scoreboard bench for obc_coef_rom_pipe with NCH=2, K=3, DATA_W=32.
module tb_obc_coef_rom_pipe;

    localparam int NCH = 2;
    localparam int K   = 3;
    localparam int DW  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_we;
    logic [0:0]      cfg_ch;
    logic [1:0]      cfg_addr;
    logic [DW-1:0]   cfg_data;
    logic            cfg_busy;
    logic            in_valid;
    logic            in_ready;
    logic [NCH*K-1:0] in_bits;
    logic            out_valid;
    logic            out_ready;
    logic [NCH*DW-1:0] out_data;
`ifdef OBC_SAT_EN
    logic [NCH-1:0]  sat_flag;
`endif

    always #5 clk = ~clk;

    obc_coef_rom_pipe #(
        .DATA_W (DW),
        .FRAC_W (21),
        .NCH    (NCH),
        .K      (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef OBC_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .out_data  (out_data)
    );

    logic [63:0] sb[$];
    logic [31:0] tbl [NCH][4];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        last_acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] coef(input logic [31:0] v, input logic s);
        if (!s) return v;
        if (v == 32'h8000_0000) begin
`ifdef OBC_SAT_EN
            return 32'h7FFF_FFFF;
`else
            return 32'h8000_0000;
`endif
        end
        return 32'd0 - v;
    endfunction

    function automatic logic [63:0] model(input logic [5:0] bits);
        logic [63:0] r;
        logic [2:0]  b;
        logic [1:0]  a;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            b = bits[c*3 +: 3];
            a = b[1:0] ^ {2{b[2]}};
            r[c*32 +: 32] = coef(tbl[c][a], b[2]);
        end
        return r;
    endfunction

    // One clock cycle: drive on the falling edge, evaluate the coming rising edge.
    task automatic cyc(input logic iv, input logic [5:0] bits, input logic ordy,
                       input logic we, input logic ch, input logic [1:0] addr,
                       input logic [31:0] data);
        @(negedge clk);
        in_valid = iv; in_bits = bits; out_ready = ordy;
        cfg_we = we; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
        #1;
        if (prev_stall) check("hold_data", out_data, prev_data);
        if (out_valid && !out_ready) check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_out", {63'd0, out_valid}, 64'd0);
            else check("out_data", out_data, sb.pop_front());
        end
        last_acc = in_valid && in_ready;
        if (last_acc) sb.push_back(model(in_bits));
        if (cfg_we) tbl[cfg_ch][cfg_addr] = cfg_data;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic send(input logic [5:0] bits);
        cyc(1'b1, bits, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic load(input logic ch, input logic [1:0] addr, input logic [31:0] data);
        cyc(1'b0, 6'd0, 1'b1, 1'b1, ch, addr, data);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            cyc(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        int busy;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_cfg_busy", {63'd0, cfg_busy}, 64'd1);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        @(posedge clk);
        #1;
`ifdef OBC_SAT_EN
        check("rst_sat_flag", {62'd0, sat_flag}, 64'd0);
`endif
        sb.delete();
        prev_stall = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < 4; a++) tbl[c][a] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!cfg_busy) break;
            busy++;
            check("init_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
        end
        check("busy_cycles", 64'(busy), 64'd4);
    endtask

    logic [5:0] pat [4];

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < 4; a++) tbl[c][a] = '0;

        // Reset and zeroed tables
        do_reset();
        send({3'b110, 3'b011});
        drain();

        // Positive lookup, then folded/negated lookup
        load(1'b0, 2'd0, 32'h0010_0000);
        load(1'b1, 2'd2, 32'h0004_0000);
        send({3'b010, 3'b000});
        drain();
        send({3'b101, 3'b111});
        drain();
        check("neg_const", model({3'b101, 3'b111}), {32'hFFFC_0000, 32'hFFF0_0000});

        // Back-to-back stream with a downstream stall on cycles 3-5
        pat[0] = {3'b010, 3'b000};
        pat[1] = {3'b101, 3'b111};
        pat[2] = {3'b000, 3'b100};
        pat[3] = {3'b111, 3'b011};
        begin
            int sent;
            sent = 0;
            for (int i = 1; i <= 30 && (sent < 4 || sb.size() > 0); i++) begin
                cyc(sent < 4, (sent < 4) ? pat[sent] : 6'd0, !(i >= 3 && i <= 5),
                    1'b0, 1'b0, 2'd0, 32'd0);
                if (last_acc) sent++;
            end
            check("stream_sent", 64'(sent), 64'd4);
            check("stream_left", 64'(sb.size()), 64'd0);
        end

        // Write and read of the same entry in one cycle
        cyc(1'b1, {3'b000, 3'b000}, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0000_0001);
        send({3'b000, 3'b000});
        drain();

        // Most negative value negated
        load(1'b0, 2'd0, 32'h8000_0000);
        send({3'b000, 3'b111});
        drain();
`ifdef OBC_SAT_EN
        check("sat_flag", {62'd0, sat_flag}, 64'd1);
`endif

        // Reset with words in flight; tables must come back zeroed
        send({3'b000, 3'b111});
        send({3'b010, 3'b000});
        do_reset();
        send({3'b000, 3'b111});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/obc_coef_rom_pipe.md
Name: obc_coef_rom_pipe

Overview:
Parametrised, registered successor of the two-entry OBC coefficient ROMs used in the 16-point DFT datapath. It holds NCH independent runtime-loadable OBC tables of depth 2^(K-1) and applies the OBC address folding and sign inversion. Each accepted input word produces NCH signed coefficients through a 2-stage pipeline with valid/ready handshake. It feeds the OBC shift-accumulate stage in place of hard-wired per-pair ROMs.

Parameters:
DATA_W, 32, coefficient width (two's complement, Q(DATA_W-FRAC_W).FRAC_W)
FRAC_W, 21, fractional bits (documentation/package constants only)
NCH, 4, number of independent channels/tables
K, 3, input bits per channel (K>=2); table depth DEPTH=2^(K-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  table write strobe
cfg_ch  in  clog2(NCH)  channel to write
cfg_addr  in  K-1  entry to write
cfg_data  in  DATA_W  entry value
cfg_busy  out  1  high while initialising; writes ignored
in_valid  in  1  input word valid
in_ready  out  1  block accepts input this cycle
in_bits  in  NCH*K  channel c uses in_bits[c*K +: K]; bit K-1 is the OBC sign bit
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_data  out  NCH*DATA_W  channel c at out_data[c*DATA_W +: DATA_W]

Behaviour:
- Reset (rst_n=0 at edge): state=INIT, init counter=0, all valids=0, out_data=0, out_valid=0, cfg_busy=1, in_ready=0.
- FSM: INIT -> each cycle writes 0 to entry cnt of all NCH tables; after entry DEPTH-1 -> READY (INIT lasts exactly DEPTH cycles). READY holds until reset. Reset mid-operation aborts the pipeline and re-zeroes the tables.
- cfg_we honoured only in READY; writes T[cfg_ch][cfg_addr]. cfg_ch>=NCH is ignored.
- Address fold per channel: s=b[K-1]; addr[j]=b[j]^s for j<K-1.
- Stage 1 (on accept): synchronous table read of T[c][addr], s registered, v1=1.
- Stage 2: out_data[c] = s ? -T : T (two's complement, DATA_W bits), out_valid=v1.
- Advance enable en = !out_valid | out_ready. in_ready = (state==READY) & en. Accept = in_valid & in_ready.
- When en=0, both stages hold and out_data is stable.
- When en=1 and no accept, v1 becomes 0 (bubble).
- Latency: 2 cycles from accept to out_valid with out_ready=1. Throughput is 1 word/cycle.
- Same-cycle cfg write and read of the same entry: the read returns the old value. The new value is visible to inputs accepted from the next cycle on.
- Negation of -2^(DATA_W-1) wraps to itself (default build).

Optional Feature:
OBC_SAT_EN
- Defined: negating -2^(DATA_W-1) yields 2^(DATA_W-1)-1, and the per-channel sticky flag sat_flag (extra output port, width NCH) is set. sat_flag clears on reset.
- Undefined: wrap behaviour as above, and there is no sat_flag port.

Decomposition:
Package obc_pkg holds:
- the FSM state enum (INIT, READY);
- the DATA_W/FRAC_W defaults;
- the Q11.21 constants COEF_HALF_POS=32'h0010_0000 and COEF_HALF_NEG=32'hFFF0_0000.

Sub-module obc_table: one channel's DEPTH x DATA_W RAM with a sync write port and a registered read port, instantiated NCH times by generate.

Test Plan (NCH=2, K=3, DATA_W=32):
1. Reset release -> cfg_busy=1 for exactly 4 cycles, in_ready=0 during them; any input then returns out_data=0.
2. Load T[0][0]=32'h0010_0000, T[1][2]=32'h0004_0000; in_bits ch0=3'b000, ch1=3'b010 -> 2 cycles later out ch0=32'h0010_0000, ch1=32'h0004_0000.
3. Same tables; ch0=3'b111, ch1=3'b101 (addr 00, 10, negate) -> ch0=32'hFFF0_0000, ch1=32'hFFFC_0000.
4. Stream 4 back-to-back words, out_ready=0 for cycles 3-5 -> in_ready low while stalled, out_data held, all 4 results delivered in order, no loss or duplication.
5. cfg write T[0][0]=32'h0000_0001 in the same cycle an input addressing it is accepted -> that result uses the old value; the next input returns 1.
6. T[0][0]=32'h8000_0000, ch0=3'b111 -> without OBC_SAT_EN out 32'h8000_0000; with it out 32'h7FFF_FFFF and sat_flag[0]=1. Then assert rst_n=0 mid-stream -> out_valid=0 next cycle, INIT re-entered.
